// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues imem reads at pc_in, queues results in order.
// Ports: clk/rst, pc_in/pc_en/next_pc, redirect_*, imem_req_*, imem_rsp_*,
// inst_* (plus inst_fault when IFETCH_MISALIGN_TRAP_EN is defined).
module ifetch_unit #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_en,
  output logic [XLEN-1:0] next_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic            inst_fault,
`endif
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  // fptr: oldest unfilled entry; ucnt: entries still awaiting data
  ptr_t head, tail, fptr;
  cnt_t count, ucnt, drop_cnt;
  cnt_t drop_sum, drop_nxt;
  logic [CW:0] occ;

  logic accept, pop, fill, drop, stall;
  logic [XLEN-1:0] redir_tgt;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic [DEPTH-1:0] fault_q;
  logic misalign;

  assign misalign   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_tgt  = redirect_pc;
  assign inst_fault = fault_q[head] && filled_q[head];
`else
  assign redir_tgt  = redirect_pc & ~XLEN'(3);
  assign stall      = 1'b0;
`endif

  // Stale responses still in flight occupy capacity like live entries
  assign occ = {1'b0, count} + {1'b0, drop_cnt};

  assign imem_req_valid = !rst && !redirect_valid && !stall &&
                          (occ < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_in;
  assign accept = imem_req_valid && imem_req_ready;

  assign inst_valid = filled_q[head] && !redirect_valid;
  assign inst_data  = data_q[head];
  assign inst_pc    = pc_q[head];
  assign pop        = inst_valid && inst_ready;

  assign drop = imem_rsp_valid && (drop_cnt != '0);
  assign fill = imem_rsp_valid && (drop_cnt == '0) &&
                (ucnt != '0) && !redirect_valid;

  // On redirect every unfilled entry turns into a pending discard;
  // a response landing in that same cycle is already one of them.
  assign drop_sum = drop_cnt + ucnt;
  assign drop_nxt = (imem_rsp_valid && drop_sum != '0) ?
                    drop_sum - cnt_t'(1) : drop_sum;

  always_comb begin
    pc_en   = 1'b0;
    next_pc = pc_in + XLEN'(4);
    if (redirect_valid) begin
      pc_en   = 1'b1;
      next_pc = redir_tgt;
    end else if (accept) begin
      pc_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      count    <= '0;
      ucnt     <= '0;
      drop_cnt <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      fault_q <= '0;
      stall   <= 1'b0;
`endif
    end else if (redirect_valid) begin
      head     <= tail;
      fptr     <= tail;
      count    <= '0;
      ucnt     <= '0;
      filled_q <= '0;
      drop_cnt <= drop_nxt;
`ifdef IFETCH_MISALIGN_TRAP_EN
      stall <= misalign;
      if (misalign) begin
        pc_q[tail]     <= redirect_pc;
        filled_q[tail] <= 1'b1;
        fault_q[tail]  <= 1'b1;
        tail           <= tail + ptr_t'(1);
        fptr           <= tail + ptr_t'(1);
        count          <= cnt_t'(1);
      end
`endif
    end else begin
      if (accept) begin
        pc_q[tail]     <= pc_in;
        filled_q[tail] <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        fault_q[tail]  <= 1'b0;
`endif
        tail           <= tail + ptr_t'(1);
      end
      if (fill) begin
        data_q[fptr]   <= imem_rsp_data;
        filled_q[fptr] <= 1'b1;
        fptr           <= fptr + ptr_t'(1);
      end
      if (pop) begin
        filled_q[head] <= 1'b0;
        head           <= head + ptr_t'(1);
      end
      if (drop)
        drop_cnt <= drop_cnt - cnt_t'(1);
      count <= count + cnt_t'(accept) - cnt_t'(pop);
      ucnt  <= ucnt + cnt_t'(accept) - cnt_t'(fill);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid && drop_cnt == '0 && ucnt == '0)
      $error("ifetch_unit: response with nothing outstanding");
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a 1-cycle memory model and a PC register
// drive the DUT; expected PCs/data are queued on request and checked on pop.
module tb_ifetch_unit;

  localparam logic [31:0] MAGIC = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in;
  logic        pc_en;
  logic [31:0] next_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        inst_fault;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .pc_in(pc_in), .pc_en(pc_en), .next_pc(next_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .inst_fault(inst_fault),
`endif
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always @(posedge clk or posedge rst)
    if (rst) pc_in <= '0;
    else if (pc_en) pc_in <= next_pc;

  logic [31:0] mem_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] exp_fetch;
  logic        rsp_en;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int accepts = 0;
  logic [31:0] last_pop_pc;
  logic obs_req_valid, obs_pc_en, obs_accept, obs_pop;
  logic obs_inst_valid, obs_rsp;
  logic [31:0] obs_next_pc;

  task automatic cycle();
    logic [31:0] e;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rsp_en && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0] ^ MAGIC;
    end
    #2;
    obs_req_valid  = imem_req_valid;
    obs_pc_en      = pc_en;
    obs_next_pc    = next_pc;
    obs_inst_valid = inst_valid;
    obs_rsp        = imem_rsp_valid;
    obs_accept     = imem_req_valid && imem_req_ready;
    obs_pop        = inst_valid && inst_ready;
    if (obs_pop) begin
      pops++;
      last_pop_pc = inst_pc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected pc=%h", inst_pc);
      end else begin
        e = exp_q.pop_front();
        if (inst_pc !== e || inst_data !== (e ^ MAGIC)) begin
          errors++;
          $display("FAIL pop pc=%h data=%h want pc=%h data=%h",
                   inst_pc, inst_data, e, e ^ MAGIC);
        end
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      checks++;
      if (inst_fault !== 1'b0) begin
        errors++;
        $display("FAIL pop_fault got=%b want=0", inst_fault);
      end
`endif
    end
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (redirect_valid) begin
      exp_q.delete();
      exp_fetch = redirect_pc & ~32'h3;
    end else if (obs_accept) begin
      accepts++;
      checks++;
      if (imem_req_addr !== exp_fetch) begin
        errors++;
        $display("FAIL req_addr got=%h want=%h", imem_req_addr, exp_fetch);
      end
      mem_q.push_back(imem_req_addr);
      exp_q.push_back(exp_fetch);
      exp_fetch += 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_pop(input string name, input logic [31:0] want);
    int p0;
    p0 = pops;
    for (int i = 0; i < 30 && pops == p0; i++) cycle();
    checks++;
    if (pops == p0 || last_pop_pc !== want) begin
      errors++;
      $display("FAIL %s first_pc got=%h want=%h pops=%0d",
               name, last_pop_pc, want, pops - p0);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
    rsp_en = 1'b0;
    mem_q.delete();
    exp_q.delete();
    exp_fetch = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid req=%b inst=%b want 0 0",
               imem_req_valid, inst_valid);
    end
    chk("reset_inst_data", inst_data, 32'h0);
    chk("reset_inst_pc", inst_pc, 32'h0);
    do_reset();
    imem_req_ready = 1'b1;
    #1;
    chk("reset_first_req", {31'h0, imem_req_valid}, 32'h1);
    chk("reset_first_addr", imem_req_addr, 32'h0);
  endtask

  task automatic test_stream();
    int a0, p0;
    do_reset();
    imem_req_ready = 1'b1;
    rsp_en = 1'b1;
    inst_ready = 1'b1;
    a0 = accepts;
    p0 = pops;
    run(12);
    chk("stream_accepts", 32'(accepts - a0), 32'd12);
    chk("stream_pops", 32'(pops - p0), 32'd10);
    chk("stream_last_pc", last_pop_pc, 32'h24);
  endtask

  task automatic test_full();
    int a0, p0;
    do_reset();
    imem_req_ready = 1'b1;
    rsp_en = 1'b1;
    a0 = accepts;
    run(8);
    chk("full_accepts", 32'(accepts - a0), 32'd4);
    chk("full_req_valid", {31'h0, obs_req_valid}, 32'h0);
    chk("full_pc_en", {31'h0, obs_pc_en}, 32'h0);
    chk("full_pc_hold", pc_in, 32'h10);
    inst_ready = 1'b1;
    p0 = pops;
    run(12);
    chk("full_resume_pops", 32'(pops - p0), 32'd12);
    chk("full_resume_last", last_pop_pc, 32'h2C);
  endtask

  task automatic test_redirect();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    chk("redir_req_valid", {31'h0, obs_req_valid}, 32'h0);
    chk("redir_next_pc", obs_next_pc, 32'h100);
    redirect_valid = 1'b0;
    cycle();
    chk("redir_empty", {31'h0, obs_inst_valid}, 32'h0);
    rsp_en = 1'b1;
    wait_pop("redirect", 32'h100);
    run(4);
  endtask

  task automatic test_redirect_rsp();
    int p0;
    do_reset();
    imem_req_ready = 1'b1;
    rsp_en = 1'b1;
    inst_ready = 1'b1;
    run(5);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    chk("rr_rsp_seen", {31'h0, obs_rsp}, 32'h1);
    chk("rr_no_pop", {31'h0, obs_pop}, 32'h0);
    redirect_valid = 1'b0;
    wait_pop("redir_rsp", 32'h40);
    p0 = pops;
    run(6);
    chk("rr_steady_pops", 32'(pops - p0), 32'd6);
  endtask

  task automatic test_back_to_back();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    rsp_en = 1'b1;
    cycle();
    chk("b2b_blocked", {31'h0, obs_req_valid}, 32'h0);
    wait_pop("b2b", 32'h200);
    run(4);
  endtask

  task automatic test_wrap();
    do_reset();
    imem_req_ready = 1'b1;
    rsp_en = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("wrap_accept", {31'h0, obs_accept}, 32'h1);
    chk("wrap_pc_en", {31'h0, obs_pc_en}, 32'h1);
    chk("wrap_next_pc", obs_next_pc, 32'h0);
    wait_pop("wrap", 32'hFFFF_FFFC);
    run(4);
  endtask

`ifdef IFETCH_MISALIGN_TRAP_EN
  task automatic test_misalign();
    do_reset();
    imem_req_ready = 1'b1;
    rsp_en = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mis_no_req", {31'h0, obs_req_valid}, 32'h0);
      chk("mis_no_pc_en", {31'h0, obs_pc_en}, 32'h0);
    end
    chk("mis_valid", {31'h0, inst_valid}, 32'h1);
    chk("mis_fault", {31'h0, inst_fault}, 32'h1);
    chk("mis_pc", inst_pc, 32'h102);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    wait_pop("mis_resume", 32'h200);
    run(4);
  endtask
`endif

  initial begin
    do_reset();
    test_stream();
    test_reset();
    test_full();
    test_redirect();
    test_redirect_rsp();
    test_back_to_back();
    test_wrap();
`ifdef IFETCH_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
